// File: rtl/seq_and_reducer.sv
// seq_and_reducer
//
// Sequential bitwise-AND reduction engine. Operands arrive one per accepted
// beat on a valid/ready input stream. They are folded into a single
// accumulator. The beat flagged in_last closes the reduction, and the result
// is then held on the output handshake until the consumer takes it.
//
// Optional feature macro: SEQ_AND_OR_MODE_EN
//   When defined, this adds the op_or input. op_or is sampled on the first
//   beat of each reduction and selects OR reduction (1) or AND reduction (0)
//   for that whole reduction.
//
// Parameters
//   WIDTH      operand/result width (>= 1)
//   MAX_BEATS  beat count at which out_count saturates (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   producer offers a beat
//   in_ready   block can accept a beat (IDLE or ACC)
//   in_data    operand
//   in_last    beat is the final operand of the reduction
//   op_or      (SEQ_AND_OR_MODE_EN only) OR-reduction select, first beat only
//   out_valid  result available (HOLD)
//   out_ready  consumer takes result
//   out_data   reduction result (accumulator register)
//   out_count  beats reduced, saturating at MAX_BEATS
//   out_ovf    more than MAX_BEATS beats were reduced

module seq_and_reducer #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef SEQ_AND_OR_MODE_EN
  input  logic             op_or,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             accept;

`ifdef SEQ_AND_OR_MODE_EN
  logic             op_or_q, op_or_d;
`endif

  // The handshake outputs are decoded from the state register only. This
  // keeps every output free of combinational paths from the inputs.
  assign in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef SEQ_AND_OR_MODE_EN
    op_or_d = op_or_q;
`endif

    case (state_q)
      IDLE: begin
        // The first beat loads the accumulator directly. The reduction mode
        // is latched here so that mid-stream changes to op_or have no effect.
        if (accept) begin
          acc_d   = in_data;
          count_d = CW'(1);
          ovf_d   = 1'b0;
`ifdef SEQ_AND_OR_MODE_EN
          op_or_d = op_or;
`endif
          state_d = in_last ? HOLD : ACC;
        end
      end

      ACC: begin
        // Beats past the limit are still folded into the accumulator.
        // Only the count saturates, and the overflow flag records it.
        if (accept) begin
`ifdef SEQ_AND_OR_MODE_EN
          acc_d = op_or_q ? (acc_q | in_data) : (acc_q & in_data);
`else
          acc_d = acc_q & in_data;
`endif
          if (count_q == MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // The result registers stay untouched until the consumer takes them.
        // in_ready is low here, so no beat is accepted in this cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset drops any partial or pending result.
  // The accumulator restarts at all ones, which is the identity for AND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= {WIDTH{1'b1}};
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef SEQ_AND_OR_MODE_EN
      op_or_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef SEQ_AND_OR_MODE_EN
      op_or_q <= op_or_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_and_reducer.sv
// tb_seq_and_reducer
//
// Directed bench for seq_and_reducer with WIDTH=8 and MAX_BEATS=4.
// A table of per-cycle vectors covers the single-beat, gapped three-beat,
// backpressure and overflow scenarios. Hand-written sequences cover
// asynchronous reset and, when SEQ_AND_OR_MODE_EN is defined, OR mode.

module tb_seq_and_reducer;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CW        = $clog2(MAX_BEATS + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             op_or;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  seq_and_reducer #(
    .WIDTH    (WIDTH),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
`ifdef SEQ_AND_OR_MODE_EN
    .op_or    (op_or),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected just after that edge.
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             l;
    logic             r;
    logic             eir;
    logic             eov;
    logic [WIDTH-1:0] ed;
    logic [CW-1:0]    ec;
    logic             eof;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [WIDTH-1:0] d,
                              input logic l, input logic r,
                              input logic eir, input logic eov,
                              input logic [WIDTH-1:0] ed,
                              input logic [CW-1:0] ec, input logic eof);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.eir = eir; t.eov = eov; t.ed = ed; t.ec = ec; t.eof = eof;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic eir,
                             input logic eov, input logic [WIDTH-1:0] ed,
                             input logic [CW-1:0] ec, input logic eof);
    checks++;
    if (in_ready !== eir || out_valid !== eov || out_data !== ed ||
        out_count !== ec || out_ovf !== eof) begin
      errors++;
      $display("[TB] FAIL %s: got ir=%b ov=%b data=%h cnt=%0d ovf=%b, expected ir=%b ov=%b data=%h cnt=%0d ovf=%b",
               name, in_ready, out_valid, out_data, out_count, out_ovf,
               eir, eov, ed, ec, eof);
    end
  endtask

  // Drive on the falling edge and let the rising edge act.
  // Outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input string name, input logic v,
                               input logic [WIDTH-1:0] d, input logic l,
                               input logic r, input logic oo,
                               input logic eir, input logic eov,
                               input logic [WIDTH-1:0] ed,
                               input logic [CW-1:0] ec, input logic eof);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    op_or     = oo;
    @(posedge clk);
    #1;
    checkOutput(name, eir, eov, ed, ec, eof);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    op_or     = 1'b0;

    // Single beat 0xA5: result visible right after the accepting edge.
    vecs.push_back(mk(1, 8'hA5, 1, 0,  0, 1, 8'hA5, 3'd1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1,  1, 0, 8'hA5, 3'd1, 0));
    // Three beats, gapped by two idle cycles: FF & F0 & 3C = 30.
    vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 0, 8'hFF, 3'd1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 0, 8'hFF, 3'd1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 0, 8'hFF, 3'd1, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 0,  1, 0, 8'hF0, 3'd2, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 0, 8'hF0, 3'd2, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 0, 8'hF0, 3'd2, 0));
    vecs.push_back(mk(1, 8'h3C, 1, 0,  0, 1, 8'h30, 3'd3, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1,  1, 0, 8'h30, 3'd3, 0));
    // Backpressure: 0F & 3F = 0F, held 5 cycles while the producer pushes.
    vecs.push_back(mk(1, 8'h0F, 0, 0,  1, 0, 8'h0F, 3'd1, 0));
    vecs.push_back(mk(1, 8'h3F, 1, 0,  0, 1, 8'h0F, 3'd2, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 8'h00, 1, 0,  0, 1, 8'h0F, 3'd2, 0));
    // Take cycle: the offered beat must not be accepted.
    vecs.push_back(mk(1, 8'h00, 1, 1,  1, 0, 8'h0F, 3'd2, 0));
    // Overflow: FF x5 then 0F(last); the count saturates at 4.
    vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 0, 8'hFF, 3'd1, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 0, 8'hFF, 3'd2, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 0, 8'hFF, 3'd3, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 0, 8'hFF, 3'd4, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 0, 8'hFF, 3'd4, 1));
    vecs.push_back(mk(1, 8'h0F, 1, 0,  0, 1, 8'h0F, 3'd4, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1,  1, 0, 8'h0F, 3'd4, 1));

    #2;
    checkOutput("reset_state", 1, 0, 8'hFF, 3'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].l,
                    vecs[i].r, 1'b0, vecs[i].eir, vecs[i].eov, vecs[i].ed,
                    vecs[i].ec, vecs[i].eof);
    end

    // Asynchronous reset mid-stream after two zero beats.
    applyStimulus("mid_b1", 1, 8'h00, 0, 0, 0,  1, 0, 8'h00, 3'd1, 0);
    applyStimulus("mid_b2", 1, 8'h00, 0, 0, 0,  1, 0, 8'h00, 3'd2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("mid_rst_async", 1, 0, 8'hFF, 3'd0, 0);
    #2;
    rst = 1'b0;
    applyStimulus("mid_idle", 0, 8'h00, 0, 0, 0,  1, 0, 8'hFF, 3'd0, 0);
    applyStimulus("mid_single", 1, 8'h11, 1, 0, 0,  0, 1, 8'h11, 3'd1, 0);

    // Reset while a result is pending drops it.
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("hold_rst_async", 1, 0, 8'hFF, 3'd0, 0);
    #2;
    rst = 1'b0;
    applyStimulus("hold_idle", 0, 8'h00, 0, 1, 0,  1, 0, 8'hFF, 3'd0, 0);

`ifdef SEQ_AND_OR_MODE_EN
    // OR mode is latched on the first beat; the toggle on beat two is ignored.
    applyStimulus("or_b1", 1, 8'h01, 0, 0, 1,  1, 0, 8'h01, 3'd1, 0);
    applyStimulus("or_b2", 1, 8'h80, 1, 0, 0,  0, 1, 8'h81, 3'd2, 0);
    applyStimulus("or_take", 0, 8'h00, 0, 1, 0,  1, 0, 8'h81, 3'd2, 0);
    applyStimulus("and_b1", 1, 8'h01, 0, 0, 0,  1, 0, 8'h01, 3'd1, 0);
    applyStimulus("and_b2", 1, 8'h80, 1, 0, 1,  0, 1, 8'h00, 3'd2, 0);
    applyStimulus("and_take", 0, 8'h00, 0, 1, 0,  1, 0, 8'h00, 3'd2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
